// File: rtl/fc_mac_engine.sv
// fc_mac_engine: serial multiply-accumulate engine for one fully connected layer.
// For each output neuron j it streams IN_SZ weights plus one bias from an external
// weight memory (one-cycle read latency), accumulates w[j][k]*x[k] + (b[j] << FRAC),
// then writes the rounded-down, saturated result to the next layer's neuron store.
//
// Optional feature: define FC_MAC_RELU_EN to clamp negative results to zero.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle evaluate request, honoured only while idle
//   in_values     IN_SZ packed SIZE-bit input neuron values (element i = x[i])
//   weight_addr   weight memory address (holds its last value outside MAC)
//   weight_data   weight memory read data, valid the cycle after weight_addr
//   load_en       write strobe to the next layer's neuron store
//   load_value    neuron value to write (held when load_en is low)
//   load_address  neuron index to write (held when load_en is low)
//   busy          high while computing or writing
//   done          one-cycle pulse after the last neuron is written
module fc_mac_engine #(
  parameter int unsigned SIZE   = 16,
  parameter int unsigned IN_SZ  = 10,
  parameter int unsigned OUT_SZ = 10,
  parameter int unsigned FRAC   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IN_SZ-1:0][SIZE-1:0]  in_values,
  output logic [SIZE-1:0]             weight_addr,
  input  logic [SIZE-1:0]             weight_data,
  output logic                        load_en,
  output logic [SIZE-1:0]             load_value,
  output logic [SIZE-1:0]             load_address,
  output logic                        busy,
  output logic                        done
);

  // Wide enough that IN_SZ full-scale products plus a shifted bias cannot overflow.
  localparam int unsigned AW = 2 * SIZE + $clog2(IN_SZ + 1);
  localparam int unsigned KW = $clog2(IN_SZ + 2);
  localparam int unsigned JW = (OUT_SZ > 1) ? $clog2(OUT_SZ) : 1;

  typedef enum logic [1:0] {StIdle, StMac, StWrite, StDone} state_e;

  state_e                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [JW-1:0]                j_q, j_d;
  logic signed [AW-1:0]         acc_q, acc_d;
  logic [IN_SZ-1:0][SIZE-1:0]   x_q, x_d;
  logic [SIZE-1:0]              waddr_q, waddr_d;
  logic [SIZE-1:0]              lval_q, lval_d;
  logic [SIZE-1:0]              laddr_q, laddr_d;

  logic [SIZE-1:0]              x_sel;
  logic signed [2*SIZE-1:0]     prod;
  logic signed [AW-1:0]         prod_ext;
  logic signed [AW-1:0]         bias_ext;
  logic signed [AW-1:0]         shifted;
  logic [AW-SIZE:0]             hi_bits;
  logic [SIZE-1:0]              sat;
  logic [SIZE-1:0]              result;

  // Datapath: in MAC cycle k the read data belongs to the address of cycle k-1.
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < int'(IN_SZ); i++) begin
      if (k_q == KW'(i + 1)) x_sel = x_q[i];
    end
    prod     = $signed(weight_data) * $signed(x_sel);
    prod_ext = {{(AW - 2 * SIZE){prod[2*SIZE-1]}}, prod};
    bias_ext = {{(AW - SIZE - FRAC){weight_data[SIZE-1]}}, weight_data, {FRAC{1'b0}}};
    shifted  = acc_q >>> FRAC;
    // In range iff all bits above the result's sign bit match it.
    hi_bits  = shifted[AW-1:SIZE-1];
    if (hi_bits == '0 || hi_bits == '1) begin
      sat = shifted[SIZE-1:0];
    end else if (shifted[AW-1]) begin
      sat = {1'b1, {(SIZE - 1){1'b0}}};
    end else begin
      sat = {1'b0, {(SIZE - 1){1'b1}}};
    end
`ifdef FC_MAC_RELU_EN
    result = sat[SIZE-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    acc_d   = acc_q;
    x_d     = x_q;
    waddr_d = waddr_q;
    lval_d  = lval_q;
    laddr_d = laddr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = in_values;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        if (k_q <= KW'(IN_SZ)) begin
          waddr_d = SIZE'(32'(j_q) * (IN_SZ + 1) + 32'(k_q));
        end
        if (k_q == KW'(IN_SZ + 1)) begin
          acc_d   = acc_q + bias_ext;
          state_d = StWrite;
        end else begin
          if (k_q != '0) acc_d = acc_q + prod_ext;
          k_d = k_q + 1'b1;
        end
      end
      StWrite: begin
        lval_d  = result;
        laddr_d = SIZE'(j_q);
        if (j_q == JW'(OUT_SZ - 1)) begin
          state_d = StDone;
        end else begin
          j_d     = j_q + 1'b1;
          k_d     = '0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      waddr_q <= '0;
      lval_q  <= '0;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      waddr_q <= waddr_d;
      lval_q  <= lval_d;
      laddr_q <= laddr_d;
    end
  end

  // Outputs follow the next-state values so the address and write data appear in
  // the same cycle they are generated, while holding their value otherwise.
  assign weight_addr  = waddr_d;
  assign load_value   = lval_d;
  assign load_address = laddr_d;
  assign load_en      = (state_q == StWrite);
  assign busy         = (state_q == StMac) || (state_q == StWrite);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_fc_mac_engine.sv
// Directed testbench for fc_mac_engine with SIZE=16, FRAC=8, IN_SZ=2, OUT_SZ=2.
module tb_fc_mac_engine;

  localparam int unsigned SIZE   = 16;
  localparam int unsigned IN_SZ  = 2;
  localparam int unsigned OUT_SZ = 2;
  localparam int unsigned FRAC   = 8;
  localparam int          BUDGET = 16;

  logic                       clk;
  logic                       rst;
  logic                       start;
  logic [IN_SZ-1:0][SIZE-1:0] in_values;
  logic [SIZE-1:0]            weight_addr;
  logic [SIZE-1:0]            weight_data;
  logic                       load_en;
  logic [SIZE-1:0]            load_value;
  logic [SIZE-1:0]            load_address;
  logic                       busy;
  logic                       done;

  int checks = 0;
  int errors = 0;

  logic [SIZE-1:0] mem [0:5];

  // Capture results of one run, indexed by cycle after the start-sampling edge.
  int              n_loads;
  int              n_done;
  int              done_cyc;
  logic [SIZE-1:0] la   [0:3];
  logic [SIZE-1:0] lv   [0:3];
  int              lc   [0:3];
  logic [SIZE-1:0] wa   [0:BUDGET];
  logic            bz   [0:BUDGET];

  fc_mac_engine #(
    .SIZE   (SIZE),
    .IN_SZ  (IN_SZ),
    .OUT_SZ (OUT_SZ),
    .FRAC   (FRAC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_values    (in_values),
    .weight_addr  (weight_addr),
    .weight_data  (weight_data),
    .load_en      (load_en),
    .load_value   (load_value),
    .load_address (load_address),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory with one-cycle read latency.
  always @(posedge clk) begin
    if (weight_addr < 16'd6) weight_data <= mem[int'(weight_addr)];
    else weight_data <= 16'hDEAD;
  end

  task automatic set_mem(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b0,
                         input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] b1);
    mem[0] = w0; mem[1] = w1; mem[2] = b0;
    mem[3] = w2; mem[4] = w3; mem[5] = b1;
  endtask

  task automatic run_capture(input int extra_start, input int change_x);
    n_loads  = 0;
    n_done   = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (load_en) begin
        if (n_loads < 4) begin
          la[n_loads] = load_address;
          lv[n_loads] = load_value;
          lc[n_loads] = c;
        end
        n_loads++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      wa[c] = weight_addr;
      bz[c] = busy;
      start = (c == extra_start);
      if (c == change_x) begin
        in_values[0] = 16'h1234;
        in_values[1] = 16'h4321;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_two(input string tag, input logic [15:0] v0, input logic [15:0] v1);
    checks++;
    if (n_loads !== 2) begin
      errors++;
      $display("FAIL %s load_count got %0d want 2", tag, n_loads);
    end
    if (n_loads >= 2) begin
      checks++;
      if (la[0] !== 16'd0 || lc[0] !== 5) begin
        errors++;
        $display("FAIL %s load0_addr_cyc got %h@%0d want 0000@5", tag, la[0], lc[0]);
      end
      checks++;
      if (lv[0] !== v0) begin
        errors++;
        $display("FAIL %s load0_value got %h want %h", tag, lv[0], v0);
      end
      checks++;
      if (la[1] !== 16'd1 || lc[1] !== 10) begin
        errors++;
        $display("FAIL %s load1_addr_cyc got %h@%0d want 0001@10", tag, la[1], lc[1]);
      end
      checks++;
      if (lv[1] !== v1) begin
        errors++;
        $display("FAIL %s load1_value got %h want %h", tag, lv[1], v1);
      end
    end
    checks++;
    if (n_done !== 1 || done_cyc !== 11) begin
      errors++;
      $display("FAIL %s done got count %0d cyc %0d want count 1 cyc 11", tag, n_done, done_cyc);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || load_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy %b done %b load_en %b want 0 0 0", busy, done, load_en);
    end
    checks++;
    if (load_value !== 16'h0 || load_address !== 16'h0 || weight_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got lv %h la %h wa %h want 0 0 0",
               load_value, load_address, weight_addr);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored got busy %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    in_values[0] = 16'h0100;
    in_values[1] = 16'h0200;
    set_mem(16'h0080, 16'h0040, 16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    run_capture(-1, -1);
`ifdef FC_MAC_RELU_EN
    check_two("basic", 16'h0200, 16'h0000);
`else
    check_two("basic", 16'h0200, 16'hFF00);
`endif
    checks++;
    if (wa[1] !== 16'd0 || wa[2] !== 16'd1 || wa[3] !== 16'd2 || wa[6] !== 16'd3 ||
        wa[8] !== 16'd5) begin
      errors++;
      $display("FAIL basic_weight_addr got %h %h %h %h %h want 0000 0001 0002 0003 0005",
               wa[1], wa[2], wa[3], wa[6], wa[8]);
    end
    checks++;
    if (bz[1] !== 1'b1 || bz[5] !== 1'b1 || bz[11] !== 1'b0 || bz[12] !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got %b %b %b %b want 1 1 0 0", bz[1], bz[5], bz[11], bz[12]);
    end
    checks++;
    if (load_en !== 1'b0 || load_value !== lv[1] || load_address !== 16'd1) begin
      errors++;
      $display("FAIL basic_hold got en %b lv %h la %h want 0 %h 0001",
               load_en, load_value, load_address, lv[1]);
    end
  endtask

  task automatic test_saturation();
    in_values[0] = 16'h7F00;
    in_values[1] = 16'h7F00;
    set_mem(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    run_capture(-1, -1);
    check_two("sat_pos", 16'h7FFF, 16'h7FFF);
    set_mem(16'h8100, 16'h8100, 16'h8100, 16'h8100, 16'h8100, 16'h8100);
    run_capture(-1, -1);
`ifdef FC_MAC_RELU_EN
    check_two("sat_neg", 16'h0000, 16'h0000);
`else
    check_two("sat_neg", 16'h8000, 16'h8000);
`endif
  endtask

  task automatic test_back_to_back();
    in_values[0] = 16'h0100;
    in_values[1] = 16'h0200;
    set_mem(16'h0080, 16'h0040, 16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    run_capture(3, 4);
`ifdef FC_MAC_RELU_EN
    check_two("busy_start", 16'h0200, 16'h0000);
`else
    check_two("busy_start", 16'h0200, 16'hFF00);
`endif
  endtask

  task automatic test_reset_mid();
    in_values[0] = 16'h0100;
    in_values[1] = 16'h0200;
    set_mem(16'h0080, 16'h0040, 16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl got busy %b load_en %b done %b want 0 0 0", busy, load_en, done);
    end
    checks++;
    if (load_value !== 16'h0 || load_address !== 16'h0 || weight_addr !== 16'h0) begin
      errors++;
      $display("FAIL midrst_data got lv %h la %h wa %h want 0 0 0",
               load_value, load_address, weight_addr);
    end
    run_capture(-1, -1);
`ifdef FC_MAC_RELU_EN
    check_two("after_rst", 16'h0200, 16'h0000);
`else
    check_two("after_rst", 16'h0200, 16'hFF00);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    in_values    = '0;
    set_mem(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_mac_engine.md
FC_MAC_ENGINE -- requirements
Module: fc_mac_engine

Interface
REQ-001 SIZE, 16, data word width in bits; signed two's-complement fixed-point.
REQ-002 IN_SZ, 10, number of input neurons consumed.
REQ-003 OUT_SZ, 10, number of output neurons produced.
REQ-004 FRAC, 8, number of fractional bits in all values, weights and biases.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle request to evaluate the layer; sampled only in IDLE.
REQ-009 in_values  in  IN_SZ x SIZE packed array  input-layer neuron values, element i = x[i].
REQ-010 weight_addr  out  SIZE  weight memory address.
REQ-011 weight_data  in  SIZE  weight memory read data, valid the cycle after weight_addr is presented.
REQ-012 load_en  out  1  write strobe to the next layer's neuron store.
REQ-013 load_value  out  SIZE  neuron value to write.
REQ-014 load_address  out  SIZE  neuron index to write.
REQ-015 busy  out  1  high in MAC and WRITE states.
REQ-016 done  out  1  one-cycle pulse when the last neuron has been written.

Function
REQ-017 Weight memory layout: row j occupies addresses j*(IN_SZ+1)+k; k=0..IN_SZ-1 hold w[j][k]; k=IN_SZ holds bias b[j].
REQ-018 States: IDLE, MAC, WRITE, DONE.
REQ-019 IDLE with start=1: snapshot in_values into internal registers, set j=0, clear acc, go to MAC; later in_values changes do not affect the result.
REQ-020 MAC lasts IN_SZ+2 cycles (k=0..IN_SZ+1): in cycles 0..IN_SZ, weight_addr=j*(IN_SZ+1)+k; in cycles 1..IN_SZ, acc += weight_data*x[k-1]; in cycle IN_SZ+1, acc += weight_data<<FRAC.
REQ-021 weight_addr holds its last value outside MAC.
REQ-022 Accumulator is signed, 2*SIZE+clog2(IN_SZ+1) bits wide, and never overflows.
REQ-023 Result = acc arithmetically shifted right by FRAC (truncation toward minus infinity), saturated to the signed SIZE range [0x8000, 0x7FFF] for SIZE=16.
REQ-024 WRITE lasts 1 cycle: load_en=1, load_address=j, load_value=result; then j==OUT_SZ-1 goes to DONE, otherwise j+1 and MAC with acc cleared.
REQ-025 DONE lasts 1 cycle with done=1, then goes to IDLE.
REQ-026 Each neuron takes IN_SZ+3 cycles; done asserts OUT_SZ*(IN_SZ+3)+1 cycles after the start-sampling edge.
REQ-027 start while not in IDLE is ignored, with no restart and no queueing.
REQ-028 start and rst high together: rst wins.
REQ-029 load_en is 0 in all states except WRITE; load_value and load_address hold their last values when load_en=0.

Reset
REQ-030 rst=1 at any clock edge, including mid-MAC or mid-WRITE, forces IDLE on that edge and discards any partial result.
REQ-031 Reset values: load_en=0, load_value=0, load_address=0, weight_addr=0, busy=0, done=0, acc=0, j=0, snapshot registers=0.

Configuration
REQ-032 Macro FC_MAC_RELU_EN defined: a negative saturated result is replaced by 0 before load_value.
REQ-033 Macro FC_MAC_RELU_EN undefined: the signed saturated result passes unchanged.

Verification (SIZE=16, FRAC=8, IN_SZ=2, OUT_SZ=2)
REQ-034 Basic dot product: x=[0x0100,0x0200]; row0 weights=[0x0080,0x0040], bias=0x0100 -> load_en with address 0, value 0x0200; done exactly 11 cycles after start.
REQ-035 ReLU: row1 weights=[0xFF00,0x0000], bias=0 -> address 1 value 0x0000 with FC_MAC_RELU_EN defined, 0xFF00 without it.
REQ-036 Saturation: x=[0x7F00,0x7F00]; all weights and biases=0x7F00 -> value 0x7FFF; all weights negated, macro undefined -> value 0x8000.
REQ-037 Start while busy: pulse start 3 cycles after the first start -> exactly two load_en pulses and one done; in_values changed mid-run -> results unchanged.
REQ-038 Reset mid-operation: rst in cycle 4 of MAC -> next cycle busy=0, load_en=0, all outputs zero; a fresh start yields the REQ-034 results and timing.
